// File: rtl/dec_display_scheduler.sv
// Shares one byte-to-decimal converter across NUM_VALS values and scans the
// digits onto a multiplexed 7-seg display. Option: LEADING_ZERO_BLANK_EN.
module dec_display_scheduler #(
  parameter int NUM_VALS    = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int MAX_VAL     = 81
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [8*NUM_VALS-1:0]   vals_in,
  input  logic                    update_in,
  output logic                    busy_out,
  output logic                    overflow_out,
  output logic [7:0]              conv_byte_out,
  input  logic [3:0]              conv_ten_in,
  input  logic [3:0]              conv_one_in,
  output logic [2*NUM_VALS-1:0]   an_out,
  output logic [6:0]              cat_out
);

  localparam int ND = 2 * NUM_VALS;
  localparam int IW = (NUM_VALS > 1) ? $clog2(NUM_VALS) : 1;
  localparam int SW = $clog2(ND);
  localparam int CW = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CAPTURE,
    COMMIT
  } state_t;

  state_t                      state;
  logic                        pending;
  logic [IW-1:0]               idx;
  logic [NUM_VALS-1:0][7:0]    snap;
  logic [ND-1:0][3:0]          shadow;
  logic [ND-1:0][3:0]          disp;
  logic [SW-1:0]               wr_one;
  logic [SW-1:0]               wr_ten;
  logic                        last;
  logic                        too_big;

  assign wr_one  = SW'({idx, 1'b0});
  assign wr_ten  = SW'({idx, 1'b1});
  assign last    = (idx == IW'(NUM_VALS - 1));
  assign too_big = ({24'd0, snap[idx]} > MAX_VAL);

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state         <= IDLE;
      pending       <= 1'b0;
      idx           <= '0;
      snap          <= '0;
      busy_out      <= 1'b0;
      overflow_out  <= 1'b0;
      conv_byte_out <= 8'd0;
      shadow        <= '0;
      disp          <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (update_in) begin
            snap     <= vals_in;
            idx      <= '0;
            busy_out <= 1'b1;
            state    <= DRIVE;
          end
        end
        DRIVE: begin
          if (update_in) pending <= 1'b1;
          conv_byte_out <= snap[idx];
          state         <= CAPTURE;
        end
        CAPTURE: begin
          if (update_in) pending <= 1'b1;
          if (too_big) begin
            shadow[wr_one] <= 4'hF;
            shadow[wr_ten] <= 4'hF;
            overflow_out   <= 1'b1;
          end else begin
            shadow[wr_one] <= conv_one_in;
            shadow[wr_ten] <= conv_ten_in;
          end
          if (last) begin
            state <= COMMIT;
          end else begin
            idx   <= idx + 1'b1;
            state <= DRIVE;
          end
        end
        COMMIT: begin
          disp <= shadow;
          // A request landing in this cycle chains straight into a new pass
          if (pending || update_in) begin
            pending <= 1'b0;
            snap    <= vals_in;
            idx     <= '0;
            state   <= DRIVE;
          end else begin
            busy_out <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [CW-1:0] cnt;
  logic [SW-1:0] scan;
  logic [3:0]    digit;
  logic          blank;
  logic [6:0]    seg;

  assign digit = disp[scan];

`ifdef LEADING_ZERO_BLANK_EN
  assign blank = scan[0] && (digit == 4'd0);
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    seg = 7'h7F;
    unique case (digit)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h7F;
    endcase
    if (blank) seg = 7'h7F;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      cnt     <= '0;
      scan    <= '0;
      an_out  <= '1;
      cat_out <= 7'h7F;
    end else begin
      if (cnt == CW'(REFRESH_DIV - 1)) begin
        cnt  <= '0;
        scan <= (scan == SW'(ND - 1)) ? '0 : scan + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      an_out  <= ~(ND'(1) << scan);
      cat_out <= seg;
    end
  end

endmodule

// File: tb/tb_dec_display_scheduler.sv
// Directed bench for dec_display_scheduler: reset, passes, overflow,
// pending collapse, scan order and reset mid-pass.
module tb_dec_display_scheduler;

  localparam int N  = 4;
  localparam int RD = 4;
  localparam int MV = 81;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [8*N-1:0] vals;
  logic           update;
  logic           busy;
  logic           ovf;
  logic [7:0]     cbyte;
  logic [3:0]     cten;
  logic [3:0]     cone;
  logic [2*N-1:0] an;
  logic [6:0]     cat;

  always #5 clk = ~clk;

  assign cten = 4'((cbyte / 8'd10) % 8'd10);
  assign cone = 4'(cbyte % 8'd10);

  dec_display_scheduler #(
    .NUM_VALS(N),
    .REFRESH_DIV(RD),
    .MAX_VAL(MV)
  ) dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .vals_in(vals),
    .update_in(update),
    .busy_out(busy),
    .overflow_out(ovf),
    .conv_byte_out(cbyte),
    .conv_ten_in(cten),
    .conv_one_in(cone),
    .an_out(an),
    .cat_out(cat)
  );

  int npass = 0;
  int ntot  = 0;
  int ev [4];
  logic [6:0] lut [10];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] exp_seg(input int d);
    int v;
    int dg;
    bit tens;
    v    = ev[d / 2];
    tens = (d % 2) == 1;
    if (v > MV) return 7'h7F;
    dg = tens ? v / 10 : v % 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (tens && dg == 0) return 7'h7F;
`endif
    return lut[dg];
  endfunction

  function automatic logic [8*N-1:0] pack(input int a, b, c, d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic read_disp(input string tag);
    for (int d = 0; d < 2 * N; d++) begin
      int w = 0;
      logic [7:0] sel;
      sel = ~(8'(1) << d);
      while (an !== sel && w < 80) begin
        tick();
        w++;
      end
      chk($sformatf("%s_d%0d", tag, d), {17'd0, an, cat},
          {17'd0, sel, exp_seg(d)});
    end
  endtask

  // Pulses update with new values; checks old digits persist while busy
  task automatic run_pass(input int a, b, c, d, output int cyc,
                          output int leaks);
    vals   = pack(a, b, c, d);
    update = 1'b1;
    tick();
    update = 1'b0;
    cyc    = 0;
    leaks  = 0;
    while (busy && cyc < 60) begin
      cyc++;
      for (int k = 0; k < 2 * N; k++)
        if (an === ~(8'(1) << k) && cat !== exp_seg(k)) leaks++;
      tick();
    end
  endtask

  int cyc;
  int leaks;
  int errs;
  logic [7:0] prev;

  initial begin
    lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    ev     = '{0, 0, 0, 0};
    rst_n  = 1'b0;
    update = 1'b0;
    vals   = '0;
    repeat (3) tick();
    chk("rst_an", {24'd0, an}, 32'hFF);
    chk("rst_cat", {25'd0, cat}, 32'h7F);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_cbyte", {24'd0, cbyte}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_an", {24'd0, an}, 32'hFE);
    chk("rel_cat", {25'd0, cat}, 32'h40);
    read_disp("zero");

    run_pass(81, 45, 9, 0, cyc, leaks);
    chk("p1_busy", cyc, 9);
    chk("p1_leak", leaks, 0);
    ev = '{81, 45, 9, 0};
    read_disp("p1");
    chk("p1_ovf", {31'd0, ovf}, 32'd0);

    run_pass(200, 82, 81, 0, cyc, leaks);
    chk("ov_busy", cyc, 9);
    chk("ov_leak", leaks, 0);
    ev = '{200, 82, 81, 0};
    chk("ov_ovf", {31'd0, ovf}, 32'd1);
    read_disp("ov");

    run_pass(81, 45, 9, 0, cyc, leaks);
    ev = '{81, 45, 9, 0};
    chk("sticky_ovf", {31'd0, ovf}, 32'd1);
    read_disp("p3");

    vals   = pack(33, 45, 9, 0);
    update = 1'b1;
    tick();
    update = 1'b0;
    cyc    = 0;
    while (busy && cyc < 60) begin
      cyc++;
      update = (cyc == 2 || cyc == 5);
      if (cyc == 2) vals = pack(12, 45, 9, 0);
      tick();
    end
    update = 1'b0;
    chk("pend_busy", cyc, 18);
    ev = '{12, 45, 9, 0};
    read_disp("pend");

    prev = an;
    for (int w = 0; w < 100; w++) begin
      tick();
      if (an === 8'hFE && prev !== 8'hFE) break;
      prev = an;
    end
    errs = 0;
    for (int i = 0; i < 36; i++) begin
      int e;
      e = (i / 4) % 8;
      if (an !== ~(8'(1) << e) || cat !== exp_seg(e)) errs++;
      tick();
    end
    chk("scan", errs, 0);

    vals   = pack(77, 66, 55, 44);
    update = 1'b1;
    tick();
    update = 1'b0;
    repeat (5) tick();
    chk("mid_busy_pre", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_an", {24'd0, an}, 32'hFF);
    chk("mid_ovf", {31'd0, ovf}, 32'd0);
    rst_n = 1'b1;
    ev = '{0, 0, 0, 0};
    read_disp("mid");
    repeat (20) tick();
    chk("mid_idle", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
